// File: rtl/verilab_pads_ctrl_pkg.sv
// Shared types and constants for the pad-ring controllers.
package verilab_pads_ctrl_pkg;

  // Bank size used when an instance does not override GPIO.
  localparam int unsigned PROJ_GPIO = 4;
  localparam int unsigned CFGW      = 3;

  typedef struct packed {
    logic oe;
    logic pull_en;
    logic pull_up;
  } pad_cfg_t;

  typedef enum logic [1:0] {IDLE, SHIFT, UPD} cfg_seq_state_t;

endpackage

// File: rtl/verilab_pads_tick_div.sv
// Free-running divider: tick marks the last cycle of each DIV-cycle period.
module verilab_pads_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == Last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick      = (cnt_q == Last);
  // Lets the owner register outputs that must line up with the tick cycle.
  assign tick_next = (cnt_d == Last);

endmodule

// File: rtl/verilab_pads_cfg_seq.sv
// Pad-ring configuration sequencer: captures a bank config, shifts it MSB-first
// onto the config chain at a divided rate, then strobes the pad latches.
module verilab_pads_cfg_seq
  import verilab_pads_ctrl_pkg::*;
#(
  parameter int unsigned GPIO = PROJ_GPIO,
  parameter int unsigned DIV  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [GPIO*3-1:0]  req_cfg,
  input  logic               abort,
  output logic               cfg_sen,
  output logic               cfg_sdo,
  output logic               cfg_upd,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int unsigned N  = GPIO * CFGW;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LastBit = BW'(N - 1);

  cfg_seq_state_t state_q, state_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic           sen_q, sdo_q, upd_q, aborted_q;
  logic           sen_d, sdo_d, upd_d, aborted_d;
  logic           tick, tick_next;

  verilab_pads_tick_div #(
    .DIV(DIV)
  ) u_tick_div (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q != SHIFT),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shadow_d  = shadow_q;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = SHIFT;
          bit_d    = '0;
          shadow_d = req_cfg;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (tick) begin
          // The bit on the chain this cycle is done; expose the next one at the MSB.
          shadow_d = shadow_q << 1;
          if (bit_q == LastBit) begin
            state_d = UPD;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sen_d = (state_d == SHIFT) && tick_next;
    sdo_d = sen_d & shadow_d[N-1];
    upd_d = (state_d == UPD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      shadow_q  <= '0;
      sen_q     <= 1'b0;
      sdo_q     <= 1'b0;
      upd_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      shadow_q  <= shadow_d;
      sen_q     <= sen_d;
      sdo_q     <= sdo_d;
      upd_q     <= upd_d;
      aborted_q <= aborted_d;
    end
  end

  assign req_ready = ~rst & (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cfg_sen   = sen_q;
  assign cfg_sdo   = sdo_q;
  assign cfg_upd   = upd_q;
  assign done      = upd_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_verilab_pads_cfg_seq.sv
// Directed bench: one DIV=2 and one DIV=1 sequencer, both GPIO=4 (12-bit chain).
module tb_verilab_pads_cfg_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid2 = 1'b0, abort2 = 1'b0;
  logic [11:0] cfg2 = '0;
  logic        ready2, sen2, sdo2, upd2, busy2, done2, ab2;
  logic        valid1 = 1'b0;
  logic        abort1 = 1'b0;
  logic [11:0] cfg1 = '0;
  logic        ready1, sen1, sdo1, upd1, busy1, done1, ab1;

  verilab_pads_cfg_seq #(.GPIO(4), .DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(valid2), .req_ready(ready2), .req_cfg(cfg2),
    .abort(abort2), .cfg_sen(sen2), .cfg_sdo(sdo2), .cfg_upd(upd2), .busy(busy2),
    .done(done2), .aborted(ab2)
  );

  verilab_pads_cfg_seq #(.GPIO(4), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1), .req_cfg(cfg1),
    .abort(abort1), .cfg_sen(sen1), .cfg_sdo(sdo1), .cfg_upd(upd1), .busy(busy1),
    .done(done1), .aborted(ab1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle traces: bit k holds the value seen in cycle T+k.
  logic [63:0] sen_m, upd_m, done_m, rdy_m, ab_m, busy_m, any_m, seq;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sen_exp(input int t0, input int div, input int n);
    logic [63:0] m = '0;
    for (int j = 0; j < n; j++) m[t0 + (j + 1) * div] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] range_m(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int j = lo; j <= hi; j++) m[j] = 1'b1;
    return m;
  endfunction

  // Inputs for cycle T are set by the caller; this steps T+1..T+ncyc.
  task automatic run(input bit sel, input int ncyc, input int abort_k, input int rst_k,
                     input bit hold);
    logic s, d, u, dn, r, a, b;
    sen_m = '0; upd_m = '0; done_m = '0; rdy_m = '0;
    ab_m = '0; busy_m = '0; any_m = '0; seq = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      if (sel) begin
        s = sen1; d = sdo1; u = upd1; dn = done1; r = ready1; a = ab1; b = busy1;
      end else begin
        s = sen2; d = sdo2; u = upd2; dn = done2; r = ready2; a = ab2; b = busy2;
      end
      sen_m[k] = s; upd_m[k] = u; done_m[k] = dn; rdy_m[k] = r;
      ab_m[k] = a; busy_m[k] = b; any_m[k] = s | d | u | dn | r | a | b;
      if (s) seq = {seq[62:0], d};
      abort2 = (k == abort_k);
      rst    = (k == rst_k);
      if (hold) begin
        if (k == 1)  cfg2   = 12'h001;
        if (k == 27) valid2 = 1'b0;
      end else begin
        valid1 = 1'b0;
        valid2 = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", {57'd0, ready2, busy2, sen2, sdo2, upd2, done2, ab2}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rst_rdy", {62'd0, ready2, busy2}, 64'd2);
    @(posedge clk);
    #1;
    check_eq("idle_rdy", {62'd0, ready2, busy2}, 64'd2);

    // Plain transfer of 12'hA5C
    cfg2 = 12'hA5C; valid2 = 1'b1;
    run(1'b0, 26, -1, -1, 1'b0);
    check_eq("a5c_sen",  sen_m,  sen_exp(0, 2, 12));
    check_eq("a5c_seq",  seq,    64'hA5C);
    check_eq("a5c_upd",  upd_m,  64'd1 << 25);
    check_eq("a5c_done", done_m, 64'd1 << 25);
    check_eq("a5c_rdy",  rdy_m,  64'd1 << 26);
    check_eq("a5c_busy", busy_m, range_m(1, 25));

    // req_valid held: FFF then 001 back to back
    cfg2 = 12'hFFF; valid2 = 1'b1;
    run(1'b0, 52, -1, -1, 1'b1);
    check_eq("hold_rdy", rdy_m, (64'd1 << 26) | (64'd1 << 52));
    check_eq("hold_sen", sen_m, sen_exp(0, 2, 12) | sen_exp(26, 2, 12));
    check_eq("hold_seq", seq,   64'hFFF001);
    check_eq("hold_upd", upd_m, (64'd1 << 25) | (64'd1 << 51));

    // Abort on the 5th shift pulse
    cfg2 = 12'hA5C; valid2 = 1'b1;
    run(1'b0, 30, 10, -1, 1'b0);
    check_eq("ab5_ab",   ab_m,   64'd1 << 11);
    check_eq("ab5_upd",  upd_m,  64'd0);
    check_eq("ab5_done", done_m, 64'd0);
    check_eq("ab5_sen",  sen_m,  sen_exp(0, 2, 5));
    check_eq("ab5_seq",  seq,    64'h14);
    check_eq("ab5_rdy",  rdy_m,  range_m(11, 30));

    // Abort on the final shift pulse
    cfg2 = 12'hA5C; valid2 = 1'b1;
    run(1'b0, 30, 24, -1, 1'b0);
    check_eq("ab12_ab",   ab_m,   64'd1 << 25);
    check_eq("ab12_upd",  upd_m,  64'd0);
    check_eq("ab12_done", done_m, 64'd0);
    check_eq("ab12_sen",  sen_m,  sen_exp(0, 2, 12));

    // Abort while idle does not block a simultaneous request
    cfg2 = 12'hA5C; valid2 = 1'b1; abort2 = 1'b1;
    run(1'b0, 26, -1, -1, 1'b0);
    check_eq("abidle_upd", upd_m, 64'd1 << 25);
    check_eq("abidle_ab",  ab_m,  64'd0);
    check_eq("abidle_seq", seq,   64'hA5C);

    // Reset in the middle of a shift
    cfg2 = 12'hA5C; valid2 = 1'b1;
    run(1'b0, 30, -1, 9, 1'b0);
    check_eq("rstmid_outs", 64'(any_m[10]), 64'd0);
    check_eq("rstmid_upd",  upd_m, 64'd0);
    check_eq("rstmid_sen",  sen_m, sen_exp(0, 2, 4));
    check_eq("rstmid_rdy",  rdy_m, range_m(11, 30));

    // DIV=1 instance
    cfg1 = 12'hA5C; valid1 = 1'b1;
    run(1'b1, 14, -1, -1, 1'b0);
    check_eq("div1_sen",  sen_m,  range_m(1, 12));
    check_eq("div1_seq",  seq,    64'hA5C);
    check_eq("div1_upd",  upd_m,  64'd1 << 13);
    check_eq("div1_done", done_m, 64'd1 << 13);
    check_eq("div1_rdy",  rdy_m,  64'd1 << 14);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
